holo_execute: RTL and testbench

Execute stage of the HoloRiscV multi-cycle RV32I core. Consumes the fields produced by decode (opcode, format, funct3/funct7, raw immediate, operand values, PC), computes the ALU result, effective memory address, and next PC, then hands off to memory/writeback. Shifts use an iterative one-bit-per-cycle shifter, so latency depends on the operation.

---
 rtl/holo_pkg.sv | 61 ++++++
 rtl/holo_shifter.sv | 53 +++++
 rtl/holo_execute.sv | 240 ++++++++++++++++++++++++
 tb/tb_holo_execute.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/holo_pkg.sv
// Shared HoloRiscV definitions: opcodes, decoded formats, execute stages,
// ALU/branch funct3 codes and the immediate extension helper.
package holo_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;

   localparam logic [2:0] FMT_R = 3'd1;
   localparam logic [2:0] FMT_I = 3'd2;
   localparam logic [2:0] FMT_S = 3'd3;
   localparam logic [2:0] FMT_B = 3'd4;
   localparam logic [2:0] FMT_U = 3'd5;
   localparam logic [2:0] FMT_J = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } stage_e;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Expand the immediate as decode stores it into a full operand.
   function automatic logic [XLEN-1:0] sext_imm(input logic [2:0] fmt,
                                                input logic [XLEN-1:0] raw);
      logic [XLEN-1:0] v;
      case (fmt)
         FMT_I, FMT_S: v = {{20{raw[11]}}, raw[11:0]};
         FMT_B:        v = {{19{raw[11]}}, raw[11:0], 1'b0};
         FMT_U:        v = {raw[31:12], 12'h000};
         FMT_J:        v = {{11{raw[20]}}, raw[20:1], 1'b0};
         default:      v = '0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/holo_shifter.sv
// Iterative one-bit-per-cycle shifter.
//   load/amount/dir/arith/din : capture operand and shift count (dir=1 right)
//   value : operand after the step taken on the coming edge
//   ready : the coming edge performs the final step
module holo_shifter
   import holo_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [4:0]      amount,
   input  logic            dir,
   input  logic            arith,
   input  logic [XLEN-1:0] din,
   output logic [XLEN-1:0] value,
   output logic            ready
);

   logic [XLEN-1:0] val_q, val_d, step_c;
   logic [4:0]      cnt_q, cnt_d;

   // One-bit step; right shifts replicate the sign only when arith is set.
   always_comb begin
      if (dir) step_c = {arith & val_q[XLEN-1], val_q[XLEN-1:1]};
      else     step_c = {val_q[XLEN-2:0], 1'b0};

      val_d = val_q;
      cnt_d = cnt_q;
      if (load) begin
         val_d = din;
         cnt_d = amount;
      end else if (cnt_q != 5'd0) begin
         val_d = step_c;
         cnt_d = cnt_q - 5'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         val_q <= '0;
         cnt_q <= '0;
      end else begin
         val_q <= val_d;
         cnt_q <= cnt_d;
      end
   end

   // Exposing the next value lets the caller register the final result on
   // the same edge as the last step, without an extra drain cycle.
   assign value = step_c;
   assign ready = (cnt_q == 5'd1);

endmodule

// File: rtl/holo_execute.sv
// HoloRiscV execute stage: ALU, branch resolution, effective address and
// next PC for one instruction per start request.
//   start + decode fields (opcode/fmt/f3/f7/rs2/imm/src1/src2/pc) : request
//   busy/done : handshake; result/rd_we/next_pc/mem_addr/mem_wdata/illegal
//   are valid with done and held until the next accept.
module holo_execute
   import holo_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [6:0]      opcode,
   input  logic [2:0]      fmt,
   input  logic [2:0]      f3,
   input  logic [6:0]      f7,
   input  logic [4:0]      rs2,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic [XLEN-1:0] pc,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            rd_we,
   output logic [XLEN-1:0] next_pc,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic            illegal
);

   stage_e          state_q, state_d;
   logic [6:0]      opcode_q, opcode_d;
   logic [2:0]      fmt_q, fmt_d, f3_q, f3_d;
   logic            f7b5_q, f7b5_d;
   logic [4:0]      rs2_q, rs2_d;
   logic [XLEN-1:0] imm_q, imm_d, src1_q, src1_d, src2_q, src2_d, pc_q, pc_d;

   logic            busy_q, busy_d, done_q, done_d, rd_we_q, rd_we_d;
   logic            illegal_q, illegal_d;
   logic [XLEN-1:0] result_q, result_d, next_pc_q, next_pc_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

   logic [XLEN-1:0] imm_x, op_b, pc_plus4, alu_res, sh_value;
   logic [4:0]      shamt;
   logic            is_alu, is_alui, is_shift, taken, sh_load_c, sh_ready;

   // Only funct7[5] distinguishes operations in RV32I.
   logic unused_f7;
   assign unused_f7 = ^{f7[6], f7[4:0]};

   assign imm_x    = sext_imm(fmt_q, imm_q);
   assign is_alu   = (opcode_q == OP_ALU);
   assign is_alui  = (opcode_q == OP_ALUI);
   assign op_b     = is_alu ? src2_q : imm_x;
   assign shamt    = is_alu ? src2_q[4:0] : rs2_q;
   assign is_shift = (is_alu || is_alui) && (f3_q == F3_SLL || f3_q == F3_SR);
   assign pc_plus4 = pc_q + XLEN'(4);

   // Shifts only reach this path with a zero amount, which returns src1.
   always_comb begin
      case (f3_q)
         F3_ADD:  alu_res = (is_alu && f7b5_q) ? src1_q - op_b : src1_q + op_b;
         F3_SLT:  alu_res = XLEN'($signed(src1_q) < $signed(op_b));
         F3_SLTU: alu_res = XLEN'(src1_q < op_b);
         F3_XOR:  alu_res = src1_q ^ op_b;
         F3_OR:   alu_res = src1_q | op_b;
         F3_AND:  alu_res = src1_q & op_b;
         default: alu_res = src1_q;
      endcase
   end

   always_comb begin
      case (f3_q)
         F3_BEQ:  taken = (src1_q == src2_q);
         F3_BNE:  taken = (src1_q != src2_q);
         F3_BLT:  taken = ($signed(src1_q) <  $signed(src2_q));
         F3_BGE:  taken = ($signed(src1_q) >= $signed(src2_q));
         F3_BLTU: taken = (src1_q <  src2_q);
         F3_BGEU: taken = (src1_q >= src2_q);
         default: taken = 1'b0;
      endcase
   end

   holo_shifter u_shifter (
      .clk    (clk),
      .rst    (rst),
      .load   (sh_load_c),
      .amount (shamt),
      .dir    (f3_q == F3_SR),
      .arith  (f7b5_q),
      .din    (src1_q),
      .value  (sh_value),
      .ready  (sh_ready)
   );

   // Next-state and output computation.
   always_comb begin
      state_d     = state_q;
      opcode_d    = opcode_q;
      fmt_d       = fmt_q;
      f3_d        = f3_q;
      f7b5_d      = f7b5_q;
      rs2_d       = rs2_q;
      imm_d       = imm_q;
      src1_d      = src1_q;
      src2_d      = src2_q;
      pc_d        = pc_q;
      result_d    = result_q;
      rd_we_d     = rd_we_q;
      next_pc_d   = next_pc_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      illegal_d   = illegal_q;
      sh_load_c   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               opcode_d = opcode;
               fmt_d    = fmt;
               f3_d     = f3;
               f7b5_d   = f7[5];
               rs2_d    = rs2;
               imm_d    = imm;
               src1_d   = src1;
               src2_d   = src2;
               pc_d     = pc;
               state_d  = ST_CALC;
            end
         end
         ST_CALC: begin
            result_d    = '0;
            rd_we_d     = 1'b0;
            illegal_d   = 1'b0;
            next_pc_d   = pc_plus4;
            mem_addr_d  = '0;
            mem_wdata_d = src2_q;
            case (opcode_q)
               OP_ALU, OP_ALUI: begin
                  result_d = alu_res;
                  rd_we_d  = 1'b1;
               end
               OP_LUI: begin
                  result_d = imm_x;
                  rd_we_d  = 1'b1;
               end
               OP_AUIPC: begin
                  result_d = pc_q + imm_x;
                  rd_we_d  = 1'b1;
               end
               OP_JAL: begin
                  result_d  = pc_plus4;
                  next_pc_d = pc_q + imm_x;
                  rd_we_d   = 1'b1;
               end
               OP_JALR: begin
                  result_d  = pc_plus4;
                  next_pc_d = (src1_q + imm_x) & ~XLEN'(1);
                  rd_we_d   = 1'b1;
               end
               OP_BRANCH: begin
                  if (f3_q == 3'b010 || f3_q == 3'b011) illegal_d = 1'b1;
                  else if (taken)                       next_pc_d = pc_q + imm_x;
               end
               OP_LOAD, OP_STORE: mem_addr_d = src1_q + imm_x;
               default:           illegal_d  = 1'b1;
            endcase
            if (is_shift && shamt != 5'd0) begin
               sh_load_c = 1'b1;
               state_d   = ST_SHIFT;
            end else begin
               state_d   = ST_DONE;
            end
         end
         ST_SHIFT: begin
            if (sh_ready) begin
               result_d = sh_value;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         opcode_q    <= '0;
         fmt_q       <= '0;
         f3_q        <= '0;
         f7b5_q      <= 1'b0;
         rs2_q       <= '0;
         imm_q       <= '0;
         src1_q      <= '0;
         src2_q      <= '0;
         pc_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= '0;
         rd_we_q     <= 1'b0;
         next_pc_q   <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         opcode_q    <= opcode_d;
         fmt_q       <= fmt_d;
         f3_q        <= f3_d;
         f7b5_q      <= f7b5_d;
         rs2_q       <= rs2_d;
         imm_q       <= imm_d;
         src1_q      <= src1_d;
         src2_q      <= src2_d;
         pc_q        <= pc_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         result_q    <= result_d;
         rd_we_q     <= rd_we_d;
         next_pc_q   <= next_pc_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         illegal_q   <= illegal_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign rd_we     = rd_we_q;
   assign next_pc   = next_pc_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_holo_execute.sv
// Directed table-driven bench for holo_execute.
module tb_holo_execute;
   import holo_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [6:0]  opcode, f7;
   logic [2:0]  fmt, f3;
   logic [4:0]  rs2;
   logic [31:0] imm, src1, src2, pc;
   logic        busy, done, rd_we, illegal;
   logic [31:0] result, next_pc, mem_addr, mem_wdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   holo_execute dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .fmt(fmt),
      .f3(f3), .f7(f7), .rs2(rs2), .imm(imm), .src1(src1), .src2(src2),
      .pc(pc), .busy(busy), .done(done), .result(result), .rd_we(rd_we),
      .next_pc(next_pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .illegal(illegal)
   );

   typedef struct {
      string       name;
      logic [6:0]  op;
      logic [2:0]  fmt;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rs2;
      logic [31:0] imm, s1, s2, pc;
      logic [31:0] res;
      logic        we;
      logic [31:0] npc;
      logic        ill;
      logic        mchk;
      logic [31:0] maddr;
      int          lat;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      opcode = v.op;  fmt = v.fmt; f3 = v.f3;  f7 = v.f7; rs2 = v.rs2;
      imm    = v.imm; src1 = v.s1; src2 = v.s2; pc = v.pc;
      start  = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      int          cyc;
      logic [31:0] held;
      @(negedge clk);
      drive(v);
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 1;
      chk({v.name, "_busy"}, 32'(busy), 32'd1);
      while (!done && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({v.name, "_latency"}, 32'(cyc), 32'(v.lat));
      chk({v.name, "_result"}, result, v.res);
      chk({v.name, "_rd_we"}, 32'(rd_we), 32'(v.we));
      chk({v.name, "_next_pc"}, next_pc, v.npc);
      chk({v.name, "_illegal"}, 32'(illegal), 32'(v.ill));
      if (v.mchk) begin
         chk({v.name, "_mem_addr"}, mem_addr, v.maddr);
         chk({v.name, "_mem_wdata"}, mem_wdata, v.s2);
      end
      held = v.res;
      @(posedge clk); #1;
      chk({v.name, "_done_pulse"}, 32'(done), 32'd0);
      chk({v.name, "_held"}, result, held);
   endtask

   initial begin
      int   ndone;
      logic saw;
      logic [31:0] last_res;

      //        name        op         fmt    f3 f7     rs2 imm            s1             s2             pc            res            we npc           ill mchk maddr     lat
      vecs[0]  = '{"add",     OP_ALU,    FMT_R, 0, 7'h00, 0, 32'h0,        32'd5,         32'd7,         32'h100, 32'd12,        1, 32'h104, 0, 0, 32'h0,    2};
      vecs[1]  = '{"sub",     OP_ALU,    FMT_R, 0, 7'h20, 0, 32'h0,        32'd5,         32'd7,         32'h100, 32'hFFFFFFFE,  1, 32'h104, 0, 0, 32'h0,    2};
      vecs[2]  = '{"add_wrap",OP_ALU,    FMT_R, 0, 7'h00, 0, 32'h0,        32'hFFFFFFFF,  32'd1,         32'h100, 32'h0,         1, 32'h104, 0, 0, 32'h0,    2};
      vecs[3]  = '{"slt",     OP_ALU,    FMT_R, 2, 7'h00, 0, 32'h0,        32'hFFFFFFFF,  32'd1,         32'h100, 32'd1,         1, 32'h104, 0, 0, 32'h0,    2};
      vecs[4]  = '{"sltu",    OP_ALU,    FMT_R, 3, 7'h00, 0, 32'h0,        32'hFFFFFFFF,  32'd1,         32'h100, 32'd0,         1, 32'h104, 0, 0, 32'h0,    2};
      vecs[5]  = '{"or",      OP_ALU,    FMT_R, 6, 7'h00, 0, 32'h0,        32'hF0,        32'h0F,        32'h100, 32'hFF,        1, 32'h104, 0, 0, 32'h0,    2};
      vecs[6]  = '{"srl3",    OP_ALU,    FMT_R, 5, 7'h00, 0, 32'h0,        32'h80000000,  32'd3,         32'h100, 32'h10000000,  1, 32'h104, 0, 0, 32'h0,    5};
      vecs[7]  = '{"sll_reg", OP_ALU,    FMT_R, 1, 7'h00, 0, 32'h0,        32'd1,         32'h21,        32'h100, 32'd2,         1, 32'h104, 0, 0, 32'h0,    3};
      vecs[8]  = '{"sra31",   OP_ALU,    FMT_R, 5, 7'h20, 0, 32'h0,        32'h80000000,  32'd31,        32'h100, 32'hFFFFFFFF,  1, 32'h104, 0, 0, 32'h0,    33};
      vecs[9]  = '{"srai4",   OP_ALUI,   FMT_I, 5, 7'h20, 4, 32'h404,      32'h80000000,  32'd0,         32'h100, 32'hF8000000,  1, 32'h104, 0, 0, 32'h0,    6};
      vecs[10] = '{"slli0",   OP_ALUI,   FMT_I, 1, 7'h00, 0, 32'h0,        32'h12345678,  32'd5,         32'h100, 32'h12345678,  1, 32'h104, 0, 0, 32'h0,    2};
      vecs[11] = '{"addi_neg",OP_ALUI,   FMT_I, 0, 7'h20, 0, 32'hFFF,      32'd10,        32'd0,         32'h100, 32'd9,         1, 32'h104, 0, 0, 32'h0,    2};
      vecs[12] = '{"xori",    OP_ALUI,   FMT_I, 4, 7'h00, 0, 32'hFFF,      32'hF0F0,      32'd0,         32'h100, 32'hFFFF0F0F,  1, 32'h104, 0, 0, 32'h0,    2};
      vecs[13] = '{"andi",    OP_ALUI,   FMT_I, 7, 7'h00, 0, 32'h0F0,      32'h1234,      32'd0,         32'h100, 32'h30,        1, 32'h104, 0, 0, 32'h0,    2};
      vecs[14] = '{"lui",     OP_LUI,    FMT_U, 0, 7'h00, 0, 32'h12345ABC, 32'd0,         32'd0,         32'h100, 32'h12345000,  1, 32'h104, 0, 0, 32'h0,    2};
      vecs[15] = '{"auipc",   OP_AUIPC,  FMT_U, 0, 7'h00, 0, 32'h00001FFF, 32'd0,         32'd0,         32'h100, 32'h1100,      1, 32'h104, 0, 0, 32'h0,    2};
      vecs[16] = '{"jal",     OP_JAL,    FMT_J, 0, 7'h00, 0, 32'h001FFFFC, 32'd0,         32'd0,         32'h200, 32'h204,       1, 32'h1FC, 0, 0, 32'h0,    2};
      vecs[17] = '{"jalr",    OP_JALR,   FMT_I, 0, 7'h00, 0, 32'h0,        32'h33,        32'd0,         32'h20,  32'h24,        1, 32'h32,  0, 0, 32'h0,    2};
      vecs[18] = '{"blt",     OP_BRANCH, FMT_B, 4, 7'h00, 0, 32'hFFE,      32'hFFFFFFFF,  32'd1,         32'h100, 32'h0,         0, 32'hFC,  0, 0, 32'h0,    2};
      vecs[19] = '{"bltu",    OP_BRANCH, FMT_B, 6, 7'h00, 0, 32'hFFE,      32'hFFFFFFFF,  32'd1,         32'h100, 32'h0,         0, 32'h104, 0, 0, 32'h0,    2};
      vecs[20] = '{"beq",     OP_BRANCH, FMT_B, 0, 7'h00, 0, 32'h008,      32'd5,         32'd5,         32'h100, 32'h0,         0, 32'h110, 0, 0, 32'h0,    2};
      vecs[21] = '{"bne_nt",  OP_BRANCH, FMT_B, 1, 7'h00, 0, 32'h008,      32'd5,         32'd5,         32'h100, 32'h0,         0, 32'h104, 0, 0, 32'h0,    2};
      vecs[22] = '{"bge",     OP_BRANCH, FMT_B, 5, 7'h00, 0, 32'h004,      32'd1,         32'hFFFFFFFF,  32'h100, 32'h0,         0, 32'h108, 0, 0, 32'h0,    2};
      vecs[23] = '{"bgeu",    OP_BRANCH, FMT_B, 7, 7'h00, 0, 32'h004,      32'd1,         32'hFFFFFFFF,  32'h100, 32'h0,         0, 32'h104, 0, 0, 32'h0,    2};
      vecs[24] = '{"br_f3_2", OP_BRANCH, FMT_B, 2, 7'h00, 0, 32'h004,      32'd1,         32'd1,         32'h100, 32'h0,         0, 32'h104, 1, 0, 32'h0,    2};
      vecs[25] = '{"store",   OP_STORE,  FMT_S, 2, 7'h00, 0, 32'hFFF,      32'h10,        32'hAB,        32'h100, 32'h0,         0, 32'h104, 0, 1, 32'h0F,   2};
      vecs[26] = '{"load",    OP_LOAD,   FMT_I, 2, 7'h00, 0, 32'h7FF,      32'h1000,      32'd0,         32'h100, 32'h0,         0, 32'h104, 0, 1, 32'h17FF, 2};
      vecs[27] = '{"illegal", 7'h7F,     3'd0,  0, 7'h00, 0, 32'h0,        32'd5,         32'd7,         32'h100, 32'h0,         0, 32'h104, 1, 0, 32'h0,    2};

      rst = 1'b1; start = 1'b0;
      opcode = '0; fmt = '0; f3 = '0; f7 = '0; rs2 = '0;
      imm = '0; src1 = '0; src2 = '0; pc = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_flags", {28'd0, busy, done, rd_we, illegal}, 32'd0);
      chk("reset_data", result | next_pc | mem_addr | mem_wdata, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) run_vec(vecs[i]);

      // start held high while busy and through the done cycle: one completion only
      @(negedge clk);
      drive('{"srl5", OP_ALU, FMT_R, 5, 7'h00, 0, 32'h0, 32'h80000000, 32'd5, 32'h100,
              32'h0, 1, 32'h0, 0, 0, 32'h0, 0});
      @(posedge clk); #1;
      src1 = 32'd1; src2 = 32'd1; f3 = 3'd0;
      ndone = 0; saw = 1'b0; last_res = '0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (saw) start = 1'b0;
         if (done) begin
            ndone++;
            last_res = result;
            saw = 1'b1;
         end
      end
      start = 1'b0;
      chk("busy_start_done_count", 32'(ndone), 32'd1);
      chk("busy_start_result", last_res, 32'h04000000);

      // reset during a long shift
      @(negedge clk);
      drive('{"srl20", OP_ALU, FMT_R, 5, 7'h00, 0, 32'h0, 32'hFFFFFFFF, 32'd20, 32'h300,
              32'h0, 1, 32'h0, 0, 0, 32'h0, 0});
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_flags", {28'd0, busy, done, rd_we, illegal}, 32'd0);
      chk("midrst_data", result | next_pc | mem_addr | mem_wdata, 32'd0);
      ndone = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("midrst_no_done", 32'(ndone), 32'd0);

      run_vec(vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
